spi_seq: RTL and testbench
==========================

SPI_SEQ -- requirements
Module: spi_seq

Interface
REQ-001 Parameter: ADDR_BYTES, 3, number of address bytes sent MSB-first after the opcode; legal values 1..4.
REQ-002 Parameter: MAX_LEN, 256, maximum data-phase byte count.
REQ-003 clk_in  input  1  sole clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-007 cmd_op  input  8  opcode byte.
REQ-008 cmd_addr  input  32  address; the low ADDR_BYTES*8 bits are used.
REQ-009 cmd_addr_en  input  1  1 = send the address phase.
REQ-010 cmd_rd  input  1  1 = data phase reads, 0 = data phase writes.
REQ-011 cmd_len  input  9  data-phase byte count; 0 = no data phase.
REQ-012 wr_data/wr_valid/wr_ready  input 8 / input 1 / output 1  write-data stream; transfer on valid&ready.
REQ-013 rd_data/rd_valid/rd_ready  output 8 / output 1 / input 1  read-data stream; transfer on valid&ready.
REQ-014 spi_read, spi_write  output  1 each  strobes to the byte engine.
REQ-015 spi_din  output  8  byte to the engine.
REQ-016 spi_dout  input  8  byte from the engine.
REQ-017 spi_busy  input  1  engine busy.
REQ-018 seq_busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse when a command completes.

Function
REQ-020 States: IDLE, OPC, ADDR, DATA, WAIT_HI, WAIT_LO, DONE.
REQ-021 On accept, all cmd_* fields are latched; cmd_len > MAX_LEN saturates to MAX_LEN; the next state is OPC.
REQ-022 Byte issue: spi_write (or spi_read) is high for exactly one cycle, with spi_din stable from the strobe cycle until spi_busy falls; the next state is WAIT_HI.
REQ-023 WAIT_HI waits for spi_busy sampled 1, then moves to WAIT_LO; WAIT_LO waits for spi_busy sampled 0, then advances to the next phase.
REQ-024 OPC issues cmd_op as a write. ADDR issues ADDR_BYTES write bytes MSB-first, and is skipped when cmd_addr_en = 0.
REQ-025 DATA write: the byte is issued only in a cycle where wr_valid = 1; wr_ready is asserted for that same single cycle, and the FSM stalls otherwise.
REQ-026 DATA read: spi_read is issued only when the read buffer is empty. spi_din = 8'h00. spi_dout is captured into the buffer one cycle after spi_busy is sampled 0 in WAIT_LO.
REQ-027 rd_valid stays high until rd_ready. The buffer frees in the cycle rd_ready is seen, and the next spi_read strobe may occur in that same cycle.
REQ-028 A 9-bit down-counter is loaded with the saturated cmd_len and decremented per completed data byte. DATA exits when the counter reaches 0, and is skipped when cmd_len = 0.
REQ-029 DONE waits until the read buffer is empty, pulses done for one cycle, then returns to IDLE.
REQ-030 spi_read and spi_write are never high in the same cycle, and are never high while spi_busy = 1.
REQ-031 cmd_valid is ignored while seq_busy = 1. wr_valid and rd_ready are ignored outside DATA/DONE.

Reset
REQ-032 While reset_n = 0: state = IDLE, counters = 0, spi_read = spi_write = 0, spi_din = 8'h00, rd_data = 8'h00, rd_valid = 0, wr_ready = 0, done = 0, seq_busy = 0, cmd_ready = 0.
REQ-033 cmd_ready rises in the first clk_in cycle after reset_n deasserts.
REQ-034 Reset mid-command aborts without a done pulse and discards any buffered read byte.

Structure
REQ-035 A shared package spi_pkg holds the state encoding, the MAX_LEN default, and opcode constants OP_READ = 8'h03, OP_PP = 8'h02, OP_WREN = 8'h06, OP_RDSR = 8'h05.
REQ-036 The one-entry read buffer is the sub-module spi_rdbuf (valid/ready, 8-bit).
REQ-037 The byte engine is instantiated alongside spi_seq, not inside it.

Verification
REQ-038 Case: cmd_op = 8'h06, addr_en = 0, len = 0. Required: exactly one spi_write with din = 8'h06, then one done pulse; no spi_read.
REQ-039 Case: op = 8'h03, addr = 0x123456, addr_en = 1, rd = 1, len = 4; engine model returns AA,BB,CC,DD. Required: writes 03,12,34,56, then 4 reads; rd_data sequence AA,BB,CC,DD; then done.
REQ-040 Case: same read with rd_ready held low for 20 cycles after the first byte. Required: no spi_read until the buffer is drained; no byte lost or duplicated.
REQ-041 Case: op = 8'h02, len = 2, wr_valid withheld for 10 cycles. Required: FSM stalls in DATA; writes 02,addr,11,22 once wr_valid supplies 11,22.
REQ-042 Case: cmd_len = 300. Required: exactly 256 data bytes, then done.
REQ-043 Case: reset_n pulsed low during the second address byte. Required: all outputs at reset values, no done pulse, cmd_ready = 1 in the first cycle after release.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command sequencer: state encoding, phase tags,
// latched command record and flash opcode constants.
package spi_pkg;
  localparam int MAX_LEN_DEF = 256;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_RDSR = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE, S_OPC, S_ADDR, S_DATA, S_WAIT_HI, S_WAIT_LO, S_DONE
  } state_t;

  // Which byte class is in flight, so WAIT_LO knows where to go next.
  typedef enum logic [1:0] {PH_OPC, PH_ADDR, PH_DATA} phase_t;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] addr;
    logic        addr_en;
    logic        rd;
  } cmd_t;

  function automatic logic [8:0] sat_len(input logic [8:0] len, input int max_len);
    return (int'(len) > max_len) ? 9'(max_len) : len;
  endfunction
endpackage

// File: rtl/spi_rdbuf.sv
// One-entry read-data holding register with a valid/ready output side.
// The producer only writes when the entry is known to be free.
module spi_rdbuf (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready
);
  logic       r_valid;
  logic [7:0] r_data;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
    end else if (in_valid) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
endmodule

// File: rtl/spi_seq.sv
// SPI flash command sequencer: opcode, optional address and read/write data
// phase, issued byte by byte to an external byte engine.
module spi_seq
  import spi_pkg::*;
#(
  parameter int ADDR_BYTES = 3,
  parameter int MAX_LEN    = MAX_LEN_DEF
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_addr_en,
  input  logic        cmd_rd,
  input  logic [8:0]  cmd_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        spi_read,
  output logic        spi_write,
  output logic [7:0]  spi_din,
  input  logic [7:0]  spi_dout,
  input  logic        spi_busy,
  output logic        seq_busy,
  output logic        done
);
  state_t     r_state, w_nxt;
  phase_t     r_phase, w_phase;
  cmd_t       r_cmd;
  logic [2:0] r_acnt;
  logic [8:0] r_cnt;
  logic [7:0] r_din, w_byte;
  logic       r_cap, r_alive;
  logic       w_adv, w_accept, w_rd_rdy, w_buf_free, w_strobe;
  state_t     w_post_addr;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_strobe  = spi_write || spi_read;
  assign cmd_ready = r_alive && (r_state == S_IDLE);
  assign seq_busy  = (r_state != S_IDLE);
  assign w_rd_rdy  = rd_ready && (r_state == S_DATA || r_state == S_DONE);
  // A byte still on its way into the buffer counts as occupying it.
  assign w_buf_free  = !r_cap && (!rd_valid || w_rd_rdy);
  assign w_post_addr = (r_cnt == 9'd0) ? S_DONE : S_DATA;
  assign spi_din     = w_strobe ? w_byte : r_din;

  always_comb begin
    w_nxt     = r_state;
    w_phase   = r_phase;
    w_byte    = 8'h00;
    spi_write = 1'b0;
    spi_read  = 1'b0;
    wr_ready  = 1'b0;
    done      = 1'b0;
    w_adv     = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_nxt = S_OPC;
      S_OPC: if (!spi_busy) begin
        spi_write = 1'b1;
        w_byte    = r_cmd.op;
        w_phase   = PH_OPC;
        w_nxt     = S_WAIT_HI;
      end
      S_ADDR: if (!spi_busy) begin
        spi_write = 1'b1;
        w_byte    = r_cmd.addr[31:24];
        w_phase   = PH_ADDR;
        w_nxt     = S_WAIT_HI;
      end
      S_DATA: if (!spi_busy) begin
        if (r_cmd.rd) begin
          if (w_buf_free) begin
            spi_read = 1'b1;
            w_phase  = PH_DATA;
            w_nxt    = S_WAIT_HI;
          end
        end else if (wr_valid) begin
          spi_write = 1'b1;
          wr_ready  = 1'b1;
          w_byte    = wr_data;
          w_phase   = PH_DATA;
          w_nxt     = S_WAIT_HI;
        end
      end
      S_WAIT_HI: if (spi_busy) w_nxt = S_WAIT_LO;
      S_WAIT_LO: if (!spi_busy) begin
        w_adv = 1'b1;
        case (r_phase)
          PH_OPC:  w_nxt = r_cmd.addr_en ? S_ADDR : w_post_addr;
          PH_ADDR: w_nxt = (r_acnt == 3'(ADDR_BYTES - 1)) ? w_post_addr : S_ADDR;
          default: w_nxt = (r_cnt == 9'd1) ? S_DONE : S_DATA;
        endcase
      end
      S_DONE: if (!r_cap && !rd_valid) begin
        done  = 1'b1;
        w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_phase <= PH_OPC;
      r_cmd   <= '0;
      r_acnt  <= 3'd0;
      r_cnt   <= 9'd0;
      r_din   <= 8'h00;
      r_cap   <= 1'b0;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_phase <= w_phase;
      r_alive <= 1'b1;
      r_cap   <= w_adv && (r_phase == PH_DATA) && r_cmd.rd;
      if (w_strobe) r_din <= w_byte;
      if (w_accept) begin
        r_cmd.op      <= cmd_op;
        // Left-justify so the first address byte always sits in [31:24].
        r_cmd.addr    <= cmd_addr << (8 * (4 - ADDR_BYTES));
        r_cmd.addr_en <= cmd_addr_en;
        r_cmd.rd      <= cmd_rd;
        r_cnt         <= sat_len(cmd_len, MAX_LEN);
        r_acnt        <= 3'd0;
      end
      if (w_adv) begin
        if (r_phase == PH_ADDR) begin
          r_acnt     <= r_acnt + 3'd1;
          r_cmd.addr <= r_cmd.addr << 8;
        end else if (r_phase == PH_DATA) begin
          r_cnt <= r_cnt - 9'd1;
        end
      end
    end
  end

  spi_rdbuf u_rdbuf (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .in_valid  (r_cap),
    .in_data   (spi_dout),
    .out_valid (rd_valid),
    .out_data  (rd_data),
    .out_ready (w_rd_rdy)
  );
endmodule

// File: tb/tb_spi_seq.sv
// Bench for spi_seq: behavioural byte engine, write/read scoreboards, directed commands.
module tb_spi_seq;
  import spi_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [7:0]  cmd_op = 8'h00;
  logic [31:0] cmd_addr = 32'h0;
  logic        cmd_addr_en = 1'b0, cmd_rd = 1'b0;
  logic [8:0]  cmd_len = 9'd0;
  logic [7:0]  wr_data;
  logic        wr_valid, wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid, rd_ready;
  logic        spi_read, spi_write;
  logic [7:0]  spi_din;
  logic [7:0]  spi_dout = 8'h00;
  logic        spi_busy;
  logic        seq_busy, done;

  int n_chk = 0, n_fail = 0;
  int nwr = 0, nrd = 0, ndone = 0;
  logic [7:0] exp_wr[$];
  logic [7:0] exp_rd[$];

  logic [7:0] eng_bytes [0:1023];
  int         eng_idx = 0;
  logic [2:0] bcnt;

  logic [7:0] wr_src [0:511];
  int         wr_idx = 0, wr_n = 0;
  logic       wr_en = 1'b0, wr_clr = 1'b0, rdy_en = 1'b1;

  assign wr_valid = wr_en && (wr_idx < wr_n);
  assign wr_data  = wr_src[wr_idx];
  assign rd_ready = rdy_en;

  spi_seq dut (
    .clk_in(clk_in), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_addr_en(cmd_addr_en), .cmd_rd(cmd_rd),
    .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .spi_read(spi_read),
    .spi_write(spi_write), .spi_din(spi_din), .spi_dout(spi_dout), .spi_busy(spi_busy),
    .seq_busy(seq_busy), .done(done)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Byte engine: busy for three cycles per strobe, read data held until the next strobe.
  always @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      spi_busy <= 1'b0;
      bcnt     <= 3'd0;
    end else if (bcnt != 3'd0) begin
      bcnt     <= bcnt - 3'd1;
      spi_busy <= (bcnt > 3'd1);
    end else if (spi_write || spi_read) begin
      spi_busy <= 1'b1;
      bcnt     <= 3'd3;
      if (spi_read) begin
        spi_dout <= eng_bytes[eng_idx];
        eng_idx  <= eng_idx + 1;
      end
    end
  end

  always @(posedge clk_in) begin
    if (wr_clr) wr_idx <= 0;
    else if (wr_valid && wr_ready) wr_idx <= wr_idx + 1;
  end

  always @(negedge clk_in) begin
    if (reset_n) begin
      if (spi_write || spi_read) begin
        chk("strb_excl", {31'd0, spi_write && spi_read}, 0);
        chk("strb_busy", {31'd0, spi_busy}, 0);
      end
      if (spi_write) begin
        nwr++;
        if (exp_wr.size() == 0) chk("wr_extra", 1, 0);
        else chk("wr_byte", {24'd0, spi_din}, {24'd0, exp_wr.pop_front()});
      end
      if (spi_read) begin
        nrd++;
        chk("rd_din", {24'd0, spi_din}, 0);
        chk("rd_gate", {31'd0, rd_valid && !rd_ready}, 0);
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_data", {24'd0, rd_data}, {24'd0, exp_rd.pop_front()});
      end
      if (done) ndone++;
    end
  end

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic aen,
                          input logic rd, input logic [8:0] len);
    @(posedge clk_in); #1;
    cmd_op = op; cmd_addr = addr; cmd_addr_en = aen; cmd_rd = rd; cmd_len = len;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !cmd_ready; i++) begin
      @(posedge clk_in); #1;
    end
    chk("cmd_accept", {31'd0, cmd_ready}, 1);
    @(posedge clk_in); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n0);
    for (int i = 0; i < 5000 && ndone == n0; i++) begin
      @(posedge clk_in); #1;
    end
    repeat (3) @(posedge clk_in);
    #1 chk(tag, ndone - n0, 1);
  endtask

  task automatic wait_nwr(input int target);
    for (int i = 0; i < 500 && nwr < target; i++) begin
      @(posedge clk_in); #1;
    end
    chk("nwr_reach", {31'd0, nwr >= target}, 1);
  endtask

  task automatic push_read(input logic [7:0] v[4], input int n);
    for (int k = 0; k < n; k++) begin
      eng_bytes[eng_idx + k] = v[k];
      exp_rd.push_back(v[k]);
    end
  endtask

  initial begin
    int n0, r0, w0;
    logic [7:0] rv[4];

    #12;
    chk("rst_outs", {14'd0, spi_read, spi_write, spi_din, rd_data, rd_valid, wr_ready, done,
                     seq_busy, cmd_ready, 1'b0}, 0);
    @(posedge clk_in); #1 reset_n = 1'b1;
    #1 chk("rdy_pre", {31'd0, cmd_ready}, 0);
    @(posedge clk_in); #1 chk("rdy_first", {31'd0, cmd_ready}, 1);

    // Write-enable: opcode only.
    n0 = ndone; r0 = nrd;
    exp_wr.push_back(OP_WREN);
    send_cmd(OP_WREN, 32'h0, 1'b0, 1'b0, 9'd0);
    wait_done("wren_done", n0);
    chk("wren_wr_left", exp_wr.size(), 0);
    chk("wren_no_rd", nrd - r0, 0);

    // Read 4 bytes at 0x123456.
    n0 = ndone; r0 = nrd;
    rv = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    push_read(rv, 4);
    exp_wr.push_back(8'h03); exp_wr.push_back(8'h12);
    exp_wr.push_back(8'h34); exp_wr.push_back(8'h56);
    send_cmd(OP_READ, 32'h00123456, 1'b1, 1'b1, 9'd4);
    wait_done("rd_done", n0);
    chk("rd_wr_left", exp_wr.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    chk("rd_count", nrd - r0, 4);

    // Same read with the consumer stalled after the first byte.
    n0 = ndone; r0 = nrd;
    rv = '{8'h01, 8'h82, 8'h43, 8'hC4};
    push_read(rv, 4);
    exp_wr.push_back(8'h03); exp_wr.push_back(8'h12);
    exp_wr.push_back(8'h34); exp_wr.push_back(8'h56);
    rdy_en = 1'b0;
    send_cmd(OP_READ, 32'h00123456, 1'b1, 1'b1, 9'd4);
    for (int i = 0; i < 500 && !rd_valid; i++) begin
      @(posedge clk_in); #1;
    end
    chk("stall_valid", {31'd0, rd_valid}, 1);
    repeat (20) @(posedge clk_in);
    #1 chk("stall_nrd", nrd - r0, 1);
    chk("stall_hold", {24'd0, rd_data}, 8'h01);
    rdy_en = 1'b1;
    wait_done("stall_done", n0);
    chk("stall_left", exp_rd.size(), 0);
    chk("stall_count", nrd - r0, 4);

    // Page program of 2 bytes with write data withheld.
    n0 = ndone; w0 = nwr;
    wr_clr = 1'b1; @(posedge clk_in); #1 wr_clr = 1'b0;
    wr_src[0] = 8'h11; wr_src[1] = 8'h22; wr_n = 2;
    exp_wr.push_back(OP_PP); exp_wr.push_back(8'hAB);
    exp_wr.push_back(8'hCD); exp_wr.push_back(8'hEF);
    exp_wr.push_back(8'h11); exp_wr.push_back(8'h22);
    send_cmd(OP_PP, 32'hFFABCDEF, 1'b1, 1'b0, 9'd2);
    wait_nwr(w0 + 4);
    repeat (14) @(posedge clk_in);
    #1 chk("pp_stall_nwr", nwr - w0, 4);
    chk("pp_stall_busy", {31'd0, seq_busy}, 1);
    chk("pp_stall_nodone", ndone - n0, 0);
    wr_en = 1'b1;
    wait_done("pp_done", n0);
    wr_en = 1'b0;
    chk("pp_wr_left", exp_wr.size(), 0);
    chk("pp_consumed", wr_idx, 2);

    // Oversized length saturates at 256 data bytes.
    n0 = ndone; w0 = nwr;
    wr_clr = 1'b1; @(posedge clk_in); #1 wr_clr = 1'b0;
    exp_wr.push_back(OP_PP);
    for (int k = 0; k < 300; k++) begin
      wr_src[k] = 8'(k) ^ 8'h5A;
      if (k < 256) exp_wr.push_back(8'(k) ^ 8'h5A);
    end
    wr_n = 300; wr_en = 1'b1;
    send_cmd(OP_PP, 32'h0, 1'b0, 1'b0, 9'd300);
    wait_done("sat_done", n0);
    wr_en = 1'b0;
    chk("sat_nwr", nwr - w0, 257);
    chk("sat_consumed", wr_idx, 256);
    chk("sat_wr_left", exp_wr.size(), 0);

    // Reset during the second address byte.
    n0 = ndone; w0 = nwr;
    rv = '{8'h10, 8'h20, 8'h30, 8'h40};
    push_read(rv, 4);
    exp_wr.push_back(8'h03); exp_wr.push_back(8'h12);
    exp_wr.push_back(8'h34); exp_wr.push_back(8'h56);
    send_cmd(OP_READ, 32'h00123456, 1'b1, 1'b1, 9'd4);
    wait_nwr(w0 + 3);
    @(posedge clk_in); #1 reset_n = 1'b0;
    #1 chk("mid_rst_outs", {14'd0, spi_read, spi_write, spi_din, rd_data, rd_valid, wr_ready,
                            done, seq_busy, cmd_ready, 1'b0}, 0);
    exp_wr.delete(); exp_rd.delete();
    eng_idx = eng_idx + 4;
    repeat (2) @(posedge clk_in);
    #1 reset_n = 1'b1;
    #1 chk("mid_rdy_pre", {31'd0, cmd_ready}, 0);
    @(posedge clk_in); #1 chk("mid_rdy_first", {31'd0, cmd_ready}, 1);
    chk("mid_idle", {31'd0, seq_busy}, 0);
    repeat (10) @(posedge clk_in);
    #1 chk("mid_no_done", ndone - n0, 0);

    // Recovery: status read of one byte.
    n0 = ndone; r0 = nrd;
    rv = '{8'h5A, 8'h00, 8'h00, 8'h00};
    push_read(rv, 1);
    exp_wr.push_back(OP_RDSR);
    send_cmd(OP_RDSR, 32'h0, 1'b0, 1'b1, 9'd1);
    wait_done("rdsr_done", n0);
    chk("rdsr_left", exp_rd.size(), 0);
    chk("rdsr_count", nrd - r0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
